// File: rtl/mac_tx_arbiter.sv
// Round-robin front end that shares one mac_tx between two frame requesters and
// enforces the inter-frame gap. Optional counters: define MAC_TX_ARB_STATS_EN.
`timescale 1ns/1ps
module mac_tx_arbiter #(
  parameter int PAYLOAD_WIDTH = 40,
  parameter int IFG_CYCLES    = 48,
  parameter int START_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  input  logic [PAYLOAD_WIDTH-1:0] req0_payload,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [PAYLOAD_WIDTH-1:0] req1_payload,
  output logic                     req1_ready,
  input  logic                     txen_i,
  output logic [PAYLOAD_WIDTH-1:0] payload_o,
  output logic                     start_o,
  output logic                     grant_o,
  output logic                     busy_o,
  output logic                     timeout_o,
  output logic [15:0]              frames_o,
  output logic [7:0]               timeouts_o
);

  localparam int TO_EFF  = (START_TIMEOUT < 1) ? 1 : START_TIMEOUT;
  localparam int IFG_EFF = (IFG_CYCLES < 1) ? 1 : IFG_CYCLES;
  localparam int CNT_MAX = (TO_EFF > IFG_EFF) ? TO_EFF : IFG_EFF;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The counter holds cycles already elapsed, so the last cycle of a phase is N-1.
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_EFF - 1);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT_TX = 3'd2,
    ST_TX      = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic [PAYLOAD_WIDTH-1:0] r_payload;
  logic                     r_start;
  logic                     r_grant;
  logic                     r_busy;
  logic                     r_timeout;
  logic                     r_last;
  logic                     w_sel;
  logic                     w_req_any;
  logic                     w_arb_open;
  logic                     w_accept;
  logic                     w_timeout;

  // Requester selection; txen_i high blocks grants after a reset mid-frame.
  always_comb begin
    w_sel      = 1'b0;
    w_req_any  = 1'b0;
    w_arb_open = (r_state == ST_IDLE) && !txen_i;
    if (req0_valid && req1_valid) begin
      w_sel     = ~r_last;
      w_req_any = 1'b1;
    end else if (req0_valid) begin
      w_sel     = 1'b0;
      w_req_any = 1'b1;
    end else if (req1_valid) begin
      w_sel     = 1'b1;
      w_req_any = 1'b1;
    end else begin
      w_sel     = 1'b0;
      w_req_any = 1'b0;
    end
    w_accept = w_arb_open && w_req_any;
  end

  assign req0_ready = w_accept && !w_sel;
  assign req1_ready = w_accept && w_sel;

  // Next-state, phase counter and timeout decision.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        w_state_nxt = ST_WAIT_TX;
        w_cnt_nxt   = CNT_ONE;
      end
      ST_WAIT_TX: begin
        if (txen_i) begin
          w_state_nxt = ST_TX;
        end else if (r_cnt >= TO_LAST) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = CNT_ONE;
          w_timeout   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_TX: begin
        if (txen_i) begin
          w_state_nxt = ST_TX;
        end else begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      ST_GAP: begin
        // A txen rising here is a late frame following a timeout.
        if (txen_i) begin
          w_state_nxt = ST_TX;
        end else if (r_cnt >= IFG_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and phase counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered outputs; r_last starts at 1 so req0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_payload <= {PAYLOAD_WIDTH{1'b0}};
      r_start   <= 1'b0;
      r_grant   <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_last    <= 1'b1;
    end else begin
      r_start   <= (w_state_nxt == ST_START);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_timeout <= w_timeout;
      if (w_accept) begin
        r_payload <= w_sel ? req1_payload : req0_payload;
        r_grant   <= w_sel;
        r_last    <= w_sel;
      end
    end
  end

  assign payload_o = r_payload;
  assign start_o   = r_start;
  assign grant_o   = r_grant;
  assign busy_o    = r_busy;
  assign timeout_o = r_timeout;

`ifdef MAC_TX_ARB_STATS_EN
  logic [15:0] r_frames;
  logic [7:0]  r_timeouts;
  logic        w_frame_done;

  assign w_frame_done = (r_state == ST_TX) && !txen_i;

  // Frame counter wraps; timeout counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frames   <= 16'd0;
      r_timeouts <= 8'd0;
    end else begin
      if (w_frame_done) begin
        r_frames <= r_frames + 16'd1;
      end
      if (r_timeout && (r_timeouts != 8'hFF)) begin
        r_timeouts <= r_timeouts + 8'd1;
      end
    end
  end

  assign frames_o   = r_frames;
  assign timeouts_o = r_timeouts;
`else
  assign frames_o   = 16'd0;
  assign timeouts_o = 8'd0;
`endif

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Randomized bench for mac_tx_arbiter: a transaction-level model predicts when the
// arbiter is free, which requester wins, and when start/timeout/busy occur.
`timescale 1ns/1ps
module tb_mac_tx_arbiter;
  localparam int PW  = 40;
  localparam int IFG = 48;
  localparam int TO  = 16;
  localparam int N_FRAMES = 50;
  localparam int MAX_CYCLES = 40000;
`ifdef MAC_TX_ARB_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0;
  logic [PW-1:0] req0_payload = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [PW-1:0] req1_payload = '0;
  logic          req1_ready;
  logic          txen_i = 1'b0;
  logic [PW-1:0] payload_o;
  logic          start_o;
  logic          grant_o;
  logic          busy_o;
  logic          timeout_o;
  logic [15:0]   frames_o;
  logic [7:0]    timeouts_o;

  mac_tx_arbiter #(.PAYLOAD_WIDTH(PW), .IFG_CYCLES(IFG), .START_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_payload(req0_payload), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_payload(req1_payload), .req1_ready(req1_ready),
    .txen_i(txen_i), .payload_o(payload_o), .start_o(start_o), .grant_o(grant_o),
    .busy_o(busy_o), .timeout_o(timeout_o), .frames_o(frames_o), .timeouts_o(timeouts_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  // Reference model: the arbiter is free from idle_from on; events are absolute cycles.
  int idle_from = 0;
  int acc_t = -100;
  int to_t = -1;
  int fr_done_t = -1;
  int tx_on = 0;
  int tx_off = 0;
  int rst_t = -100;
  int n_acc = 0;
  int exp_frames = 0;
  int exp_touts = 0;
  bit last = 1'b1;
  bit exp_grant = 1'b0;
  logic [PW-1:0] exp_payload = '0;
  bit hold0 = 1'b0;
  bit hold1 = 1'b0;
  logic [PW-1:0] rnd0 = '0;
  logic [PW-1:0] rnd1 = '0;
  logic g_dut [4];

  initial begin
    bit free, v0, v1, sel, acc;
    int s, d, l, kind;

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_payload", payload_o, 64'd0);
    check_eq("rst_start", start_o, 64'd0);
    check_eq("rst_busy", busy_o, 64'd0);
    check_eq("rst_grant", grant_o, 64'd0);
    check_eq("rst_timeout", timeout_o, 64'd0);
    check_eq("rst_frames", frames_o, 64'd0);
    check_eq("rst_timeouts", timeouts_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    while (n_acc < N_FRAMES && t < MAX_CYCLES) begin
      @(negedge clk);
      if (t == rst_t) begin
        rst_n = 1'b0;
        idle_from = t; acc_t = -100; to_t = -1; fr_done_t = -1;
        last = 1'b1; exp_grant = 1'b0; exp_payload = '0;
        exp_frames = 0; exp_touts = 0;
      end
      if (t == rst_t + 4) rst_n = 1'b1;
      txen_i = (t >= tx_on) && (t < tx_off);

      // Requester stimulus by phase.
      if (n_acc < 4) begin
        v0 = 1'b1; v1 = 1'b1;
        req0_payload = 40'h00_0000_000A; req1_payload = 40'h00_0000_000B;
      end else if (n_acc == 4) begin
        v0 = 1'b1; v1 = 1'b0; req0_payload = 40'h01_0002_0001;
      end else if (n_acc == 5) begin
        v0 = 1'b0; v1 = 1'b1; req1_payload = 40'h5A_A55A_A55A;
      end else if (n_acc == 41) begin
        v0 = 1'b1; v1 = 1'b0; req0_payload = 40'hC0_FFEE_0001;
      end else begin
        if (!hold0 && $urandom_range(3, 0) == 0) begin
          hold0 = 1'b1; rnd0 = PW'({$urandom, $urandom});
        end else if (hold0 && $urandom_range(31, 0) == 0) begin
          hold0 = 1'b0;
        end
        if (!hold1 && $urandom_range(3, 0) == 0) begin
          hold1 = 1'b1; rnd1 = PW'({$urandom, $urandom});
        end else if (hold1 && $urandom_range(31, 0) == 0) begin
          hold1 = 1'b0;
        end
        v0 = hold0; v1 = hold1;
        req0_payload = rnd0; req1_payload = rnd1;
      end
      req0_valid = v0; req1_valid = v1;
      #1;

      free = (t >= idle_from) && !txen_i;
      sel  = (v0 && v1) ? ~last : !v0;
      acc  = free && (v0 || v1);
      check_eq("ready", {req1_ready, req0_ready}, {acc && sel, acc && !sel});
      check_eq("ready_excl", req0_ready && req1_ready, 64'd0);
      check_eq("start", start_o, t == acc_t + 1);
      check_eq("busy", busy_o, (t > acc_t) && (t < idle_from));
      check_eq("timeout", timeout_o, t == to_t);
      check_eq("grant", grant_o, exp_grant);
      check_eq("payload", payload_o, exp_payload);
      check_eq("frames", frames_o, STATS_EN ? exp_frames : 0);
      check_eq("timeouts", timeouts_o, STATS_EN ? exp_touts : 0);

      if (acc) begin
        if (n_acc < 4) g_dut[n_acc] = req1_ready;
        last = sel; exp_grant = sel;
        exp_payload = sel ? req1_payload : req0_payload;
        if (sel) hold1 = 1'b0; else hold0 = 1'b0;
        acc_t = t; s = t + 1;
        kind = $urandom_range(19, 0);
        d = $urandom_range(TO - 1, 1);
        l = $urandom_range(20, 1);
        if (n_acc < 4) kind = 0;
        if (n_acc == 4) begin kind = 0; d = 3; l = 200; end
        if (n_acc == 5) kind = 15;
        if (n_acc == 40) begin kind = 0; d = 2; l = 40; rst_t = s + d + 3; end
        if (kind < 14) begin
          tx_on = s + d; tx_off = tx_on + l;
          idle_from = tx_off + IFG; fr_done_t = tx_off; to_t = -1;
        end else if (kind < 17) begin
          tx_on = 0; tx_off = 0;
          idle_from = s + TO + IFG - 1; to_t = s + TO; fr_done_t = -1;
        end else begin
          tx_on = s + TO + $urandom_range(IFG - 2, 0); tx_off = tx_on + l;
          idle_from = tx_off + IFG; to_t = s + TO; fr_done_t = tx_off;
        end
        n_acc++;
      end
      if (t == fr_done_t) exp_frames++;
      if (t == to_t && exp_touts < 255) exp_touts++;
      t++;
    end

    check_eq("frames_done_in_budget", n_acc, N_FRAMES);
    for (int k = 0; k < 4; k++) check_eq("rr_order", g_dut[k], k % 2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mac_tx_arbiter.md
Name: mac_tx_arbiter

Overview:
- Shares one mac_tx instance between two frame requesters, e.g. requester 0 = bus read-response path, requester 1 = event/log path.
- Accepts a payload from one requester via a valid/ready handshake, then pulses mac_tx start.
- Tracks the frame by monitoring txen and enforces the inter-frame gap before granting again.
- Sits between the bus-side response logic and mac_tx, clocked on the RMII clk.

Parameters:
- PAYLOAD_WIDTH, 40, payload bits per frame; must match mac_tx payload width (PAYLOAD_LENGTH_BYTES*8).
- IFG_CYCLES, 48, idle clk cycles enforced after txen falls (96 bit times at 2 bits/clk).
- START_TIMEOUT, 16, max clk cycles from start_o to txen rising before the frame is abandoned.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a frame.
- req0_payload  in  PAYLOAD_WIDTH  requester 0 frame payload.
- req0_ready  out  1  requester 0 payload accepted this cycle.
- req1_valid  in  1  requester 1 has a frame.
- req1_payload  in  PAYLOAD_WIDTH  requester 1 frame payload.
- req1_ready  out  1  requester 1 payload accepted this cycle.
- txen_i  in  1  mac_tx txen, monitored.
- payload_o  out  PAYLOAD_WIDTH  to mac_tx payload; registered.
- start_o  out  1  to mac_tx start; one-cycle pulse.
- grant_o  out  1  index of the requester owning the current or last frame.
- busy_o  out  1  high in every state except IDLE.
- timeout_o  out  1  one-cycle pulse when START_TIMEOUT expires.
- frames_o  out  16  frames completed (optional feature).
- timeouts_o  out  8  timeouts seen (optional feature).

Behaviour:
- Reset (rst_n low, async): state IDLE; payload_o=0, start_o=0, grant_o=0, busy_o=0, timeout_o=0, counters=0, rr pointer set so req0 wins the first tie.
- The reset is async on assertion; this spec does not require a synchronizer on deassertion.
- States: IDLE, START, WAIT_TX, TX, GAP.
- IDLE:
  - reqN_ready is combinational and is high only for the selected requester.
  - Selection happens only when txen_i=0. This covers reset mid-frame while mac_tx is still transmitting.
  - If only one valid is high, that requester is selected.
  - If both are high, the requester not served last is selected (round-robin).
  - On valid&ready: latch payload into payload_o, set grant_o, update the rr pointer, go to START.
  - A requester must hold valid and payload stable until ready. Dropping valid before ready is legal: no grant, no state change.
- START: start_o=1 for exactly this cycle; go to WAIT_TX; clear the timeout counter.
- WAIT_TX:
  - txen_i=1 -> TX.
  - Otherwise increment the counter. On reaching START_TIMEOUT: pulse timeout_o, go to GAP.
- TX: stay while txen_i=1. On txen_i=0 go to GAP; the frame counts as completed.
- GAP: count IFG_CYCLES cycles, then go to IDLE.
  - txen_i rising during GAP is a late frame after a timeout: go to TX, no new start.
- Latency: valid at cycle n in IDLE -> ready at n, start_o and new payload_o at n+1. payload_o holds until the next acceptance.
- Back-to-back throughput: accepts at most one frame per (frame length + IFG_CYCLES + 2) cycles.
- Counters are wide enough for max(START_TIMEOUT, IFG_CYCLES); parameter value 0 is treated as 1.
- Both ready outputs are never high in the same cycle.

Optional Feature:
- MAC_TX_ARB_STATS_EN defined:
  - frames_o increments on each TX->GAP transition, wrapping at 2^16.
  - timeouts_o increments on each timeout_o pulse, saturating at 255.
  - Both are cleared by reset.
- Not defined: frames_o and timeouts_o are tied to 0 and no counter logic is synthesized.

Test Plan:
- Single request: req0 valid with 40'h01_0002_0001, txen_i model high for 200 cycles starting 3 cycles after start -> req0_ready one cycle, start_o one pulse, payload_o=40'h01_0002_0001, busy_o falls 48 cycles after txen falls.
- Contention: req0 and req1 valid together, payloads 40'hA and 40'hB, both held -> grant order 0, 1, 0, 1 across four frames; ready never high for both.
- Timeout: txen_i held 0 after start -> timeout_o pulse exactly 16 cycles after start_o, then 48 idle cycles, then IDLE; timeouts_o=1 with stats enabled.
- IFG enforcement: req1 valid immediately after txen falls -> req1_ready not before 48 cycles later.
- Reset mid-frame: assert rst_n low during TX while txen_i=1, release, req0 valid -> outputs at reset values; no ready until txen_i=0.
- Stats: 70000 completed frames with MAC_TX_ARB_STATS_EN -> frames_o=70000 mod 65536=4464; without the macro, frames_o=0.
